serial_digit_adder: RTL and testbench
=====================================

// Module: serial_digit_adder
// PURPOSE
//  Multi-cycle, parametrised add/subtract unit: WIDTH-bit operands processed DIGIT bits
//  per clock through one DIGIT-bit ripple slice, with a registered carry between digits.
//  Trades latency for area in datapaths that need wide adds but not single-cycle results.
//  Start/done handshake; provides carry-out and signed-overflow flags.
// PARAMETERS
//  WIDTH  32  operand/result width in bits; must be a multiple of DIGIT
//  DIGIT   4  bits processed per cycle; 1 <= DIGIT <= WIDTH
// PORTS
//  clk    in   1      single clock, rising edge
//  rst_n  in   1      asynchronous, active-low reset
//  start  in   1      request; sampled only in IDLE
//  a      in   WIDTH  operand A, captured on accepted start
//  b      in   WIDTH  operand B, captured on accepted start
//  ci     in   1      carry-in (borrow-in when sub=1), captured on accepted start
//  sub    in   1      0: s=a+b+ci; 1: s=a-b-ci, computed as a+~b+!ci
//  busy   out  1      high from the cycle after accept until done
//  done   out  1      one-cycle pulse when s/co/ovf become valid
//  s      out  WIDTH  result; holds until next accepted start
//  co     out  1      carry-out of MSB (for sub: 1 = no borrow)
//  ovf    out  1      two's-complement overflow of the final result
// BEHAVIOUR
//  - Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, s=0, co=0, ovf=0;
//    internal operand regs, carry and digit counter cleared. Reset mid-operation aborts it.
//  - NDIG = WIDTH/DIGIT; counter width = clog2(NDIG), minimum 1.
//  - IDLE: if start=1 at an edge -> capture A=a, B=(sub ? ~b : b), C=(sub ? ~ci : ci);
//    cnt=0; go to RUN. busy rises on the following cycle.
//  - RUN: each cycle adds digit cnt: {c',d}=A[cnt*DIGIT+:DIGIT]+B[...]+C; writes d into
//    s[cnt*DIGIT+:DIGIT]; C<=c'. On cnt==NDIG-1: co<=c'; ovf<=carry into MSB ^ c';
//    go to DONE. Otherwise cnt<=cnt+1.
//  - DONE: done=1 for exactly one cycle; busy=0; -> IDLE. s/co/ovf are valid while done=1.
//  - Latency: accept edge -> done high NDIG+1 cycles later; throughput 1 op per NDIG+2 cycles.
//  - start while busy or done=1: ignored, no effect on the running operation.
//  - start held high continuously: a new operation is accepted on each return to IDLE.
//  - s is updated digit by digit during RUN; consumers must use s only while done=1 or later.
//  - Wrap-around: results are modulo 2^WIDTH; the carry out of the last digit is reported
//    only via co; it is never fed into a subsequent operation.
//  - DIGIT==WIDTH: NDIG=1, one RUN cycle, latency 2.
//  - Operand/mode inputs are don't-care except at the accepting edge.
// STRUCTURE
//  - Shared package: state encoding (IDLE, RUN, DONE) and the clog2 helper for counter width.
//  - Sub-module: digit_adder #(DIGIT) -- purely combinational DIGIT-bit ripple slice
//    (a, b, ci -> s, co, c_msb where c_msb is the carry into the top bit).
//    Instantiated once; the top level holds the FSM, counter, operand regs and carry reg.
// TESTING
//  - Reset: assert rst_n=0 mid-RUN -> busy=0, done=0, s=0, co=0, ovf=0 immediately;
//    no done pulse follows after release.
//  - Add, W=32/D=4: a=0x0000_00FF, b=0x0000_0001, ci=0 -> done 9 cycles after accept,
//    s=0x0000_0100, co=0, ovf=0.
//  - Carry wrap: a=0xFFFF_FFFF, b=0x0000_0001, ci=0 -> s=0, co=1, ovf=0.
//  - Signed overflow: a=0x7FFF_FFFF, b=1, ci=0 -> s=0x8000_0000, co=0, ovf=1.
//  - Subtract: sub=1, a=5, b=7, ci=0 -> s=0xFFFF_FFFE, co=0 (borrow), ovf=0;
//    sub=1, a=0x8000_0000, b=1 -> s=0x7FFF_FFFF, ovf=1.
//  - Handshake: pulse start again while busy with different operands -> ignored;
//    result matches the first operation. With start held high -> one done every NDIG+2 cycles.
//  - Parameter sweep: D=1 and D=32 (W=32) against a reference model for random operands;
//    D=32 gives latency 2.

Source files
------------

// File: rtl/serial_digit_adder_pkg.sv
// Shared types and helpers for the digit-serial add/subtract unit.
package serial_digit_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  // Bits needed to count n values, never less than one.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/serial_digit_adder_digit.sv
// Combinational DIGIT-bit ripple slice; c_msb is the carry into the top bit.
module digit_adder #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co    = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_digit_adder.sv
// Multi-cycle add/subtract: one DIGIT-bit slice reused NDIG times with a registered carry.
module serial_digit_adder
  import serial_digit_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = clog2_min1(NDIG);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  state_e           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, a_nxt, b_nxt, s_nxt;
  logic             c_q, c_nxt, co_nxt, ovf_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [DIGIT-1:0] a_dig, b_dig, d_dig;
  logic             d_co, d_cmsb;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a     (a_dig),
    .b     (b_dig),
    .ci    (c_q),
    .s     (d_dig),
    .co    (d_co),
    .c_msb (d_cmsb)
  );

  // Select the operand digit addressed by the counter.
  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (cnt == CW'(i)) begin
        a_dig = a_q[i*DIGIT +: DIGIT];
        b_dig = b_q[i*DIGIT +: DIGIT];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    a_nxt     = a_q;
    b_nxt     = b_q;
    c_nxt     = c_q;
    cnt_nxt   = cnt;
    s_nxt     = s;
    co_nxt    = co;
    ovf_nxt   = ovf;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_RUN;
          a_nxt     = a;
          b_nxt     = sub ? ~b : b;
          c_nxt     = sub ? ~ci : ci;
          cnt_nxt   = '0;
        end
      end
      ST_RUN: begin
        for (int i = 0; i < NDIG; i++) begin
          if (cnt == CW'(i)) s_nxt[i*DIGIT +: DIGIT] = d_dig;
        end
        c_nxt = d_co;
        if (cnt == LAST) begin
          co_nxt    = d_co;
          ovf_nxt   = d_cmsb ^ d_co;
          state_nxt = ST_DONE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= 1'b0;
      cnt   <= '0;
      s     <= '0;
      co    <= 1'b0;
      ovf   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      a_q   <= a_nxt;
      b_q   <= b_nxt;
      c_q   <= c_nxt;
      cnt   <= cnt_nxt;
      s     <= s_nxt;
      co    <= co_nxt;
      ovf   <= ovf_nxt;
      busy  <= (state_nxt == ST_RUN);
      done  <= (state_nxt == ST_DONE);
    end
  end

endmodule

// File: tb/tb_serial_digit_adder.sv
// Bench for serial_digit_adder at DIGIT=4, 1 and 32 (WIDTH=32) against an arithmetic model.
module tb_serial_digit_adder;

  localparam int unsigned W = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic         clk = 1'b0;
  logic         rst_n, start, ci, sub;
  logic [W-1:0] a, b;
  logic         busy_v[3], done_v[3], co_v[3], ovf_v[3];
  logic [W-1:0] s_v[3];
  int           checks = 0;
  int           failures = 0;

  always #5 clk = ~clk;

  serial_digit_adder #(.WIDTH(W), .DIGIT(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .ci(ci), .sub(sub),
    .busy(busy_v[0]), .done(done_v[0]), .s(s_v[0]), .co(co_v[0]), .ovf(ovf_v[0]));
  serial_digit_adder #(.WIDTH(W), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .ci(ci), .sub(sub),
    .busy(busy_v[1]), .done(done_v[1]), .s(s_v[1]), .co(co_v[1]), .ovf(ovf_v[1]));
  serial_digit_adder #(.WIDTH(W), .DIGIT(32)) u_d32 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .ci(ci), .sub(sub),
    .busy(busy_v[2]), .done(done_v[2]), .s(s_v[2]), .co(co_v[2]), .ovf(ovf_v[2]));

  function automatic int unsigned dig_of(input int k);
    return (k == 0) ? 4 : (k == 1) ? 1 : 32;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Returns {ovf, co, s} from signed/unsigned integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c, input logic sb);
    longint sx, sy, ux, uy, r, ur;
    logic   o, cy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'd0, x});
    uy = longint'({32'd0, y});
    r  = sb ? (sx - sy - longint'(c)) : (sx + sy + longint'(c));
    ur = sb ? (ux - uy - longint'(c)) : (ux + uy + longint'(c));
    o  = (r > SMAX) || (r < SMIN);
    cy = sb ? (ur >= 0) : (ur > 64'sd4294967295);
    return {o, cy, ur[W-1:0]};
  endfunction

  // One start pulse; checks latency, single done pulse and result on every DUT.
  task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic c, input logic sb,
                        output logic [W-1:0] s4, output logic co4, output logic ovf4);
    logic [W+1:0] exp;
    int           seen[3], dcnt[3];
    logic [W-1:0] rs[3];
    logic         rco[3], rovf[3];
    exp = model(x, y, c, sb);
    for (int k = 0; k < 3; k++) begin
      seen[k] = 0; dcnt[k] = 0; rs[k] = '0; rco[k] = 1'b0; rovf[k] = 1'b0;
    end
    @(negedge clk);
    a = x; b = y; ci = c; sub = sb; start = 1'b1;
    for (int e = 1; e <= 45; e++) begin
      @(posedge clk); #1;
      if (e == 1) begin
        start = 1'b0; a = $urandom; b = $urandom; ci = 1'($urandom); sub = 1'($urandom);
      end
      for (int k = 0; k < 3; k++) begin
        if (done_v[k]) begin
          dcnt[k]++;
          if (seen[k] == 0) begin
            seen[k] = e; rs[k] = s_v[k]; rco[k] = co_v[k]; rovf[k] = ovf_v[k];
          end
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s d%0d latency", tag, dig_of(k)), 64'(seen[k]), 64'(W / dig_of(k) + 1));
      check($sformatf("%s d%0d done_pulses", tag, dig_of(k)), 64'(dcnt[k]), 64'd1);
      check($sformatf("%s d%0d s", tag, dig_of(k)), 64'(rs[k]), 64'(exp[W-1:0]));
      check($sformatf("%s d%0d co", tag, dig_of(k)), 64'(rco[k]), 64'(exp[W]));
      check($sformatf("%s d%0d ovf", tag, dig_of(k)), 64'(rovf[k]), 64'(exp[W+1]));
      check($sformatf("%s d%0d s_hold", tag, dig_of(k)), 64'(s_v[k]), 64'(exp[W-1:0]));
    end
    s4 = rs[0]; co4 = rco[0]; ovf4 = rovf[0];
  endtask

  initial begin
    logic [W-1:0] rs;
    logic         rc, ro;
    logic [W+1:0] exp;
    logic [W-1:0] hs_a, hs_b;
    int           d4e[$], d32e[$], dn, e4, rs_e;
    logic [W-1:0] hs_s4, hs_s1;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0;
    #12;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset d%0d busy", dig_of(k)), 64'(busy_v[k]), 64'd0);
      check($sformatf("reset d%0d done", dig_of(k)), 64'(done_v[k]), 64'd0);
      check($sformatf("reset d%0d s", dig_of(k)), 64'(s_v[k]), 64'd0);
    end
    @(negedge clk); rst_n = 1'b1;

    run_op("add", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, rs, rc, ro);
    check("add s const", 64'(rs), 64'h100);
    check("add co const", 64'(rc), 64'd0);
    check("add ovf const", 64'(ro), 64'd0);
    run_op("wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, rs, rc, ro);
    check("wrap s const", 64'(rs), 64'h0);
    check("wrap co const", 64'(rc), 64'd1);
    run_op("sovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, rs, rc, ro);
    check("sovf s const", 64'(rs), 64'h8000_0000);
    check("sovf ovf const", 64'(ro), 64'd1);
    run_op("sub", 32'd5, 32'd7, 1'b0, 1'b1, rs, rc, ro);
    check("sub s const", 64'(rs), 64'hFFFF_FFFE);
    check("sub co const", 64'(rc), 64'd0);
    check("sub ovf const", 64'(ro), 64'd0);
    run_op("subovf", 32'h8000_0000, 32'd1, 1'b0, 1'b1, rs, rc, ro);
    check("subovf s const", 64'(rs), 64'h7FFF_FFFF);
    check("subovf ovf const", 64'(ro), 64'd1);
    run_op("addci", 32'hFFFF_FFFE, 32'd0, 1'b1, 1'b0, rs, rc, ro);
    run_op("subci", 32'd0, 32'd0, 1'b1, 1'b1, rs, rc, ro);
    check("subci s const", 64'(rs), 64'hFFFF_FFFF);
    for (int i = 0; i < 8; i++)
      run_op($sformatf("rnd%0d", i), $urandom, $urandom, 1'($urandom), 1'($urandom), rs, rc, ro);

    // Start pulsed again mid-run with other operands must not disturb d4/d1.
    hs_a = $urandom; hs_b = $urandom;
    exp = model(hs_a, hs_b, 1'b1, 1'b0);
    hs_s4 = '0; hs_s1 = '0; e4 = 0;
    @(negedge clk);
    a = hs_a; b = hs_b; ci = 1'b1; sub = 1'b0; start = 1'b1;
    for (int e = 1; e <= 45; e++) begin
      @(posedge clk); #1;
      start = (e == 3);
      if (e == 3) begin a = $urandom; b = $urandom; ci = 1'b0; sub = 1'b1; end
      if (done_v[0] && e4 == 0) begin e4 = e; hs_s4 = s_v[0]; end
      if (done_v[1]) hs_s1 = s_v[1];
    end
    check("handshake d4 latency", 64'(e4), 64'd9);
    check("handshake d4 s", 64'(hs_s4), 64'(exp[W-1:0]));
    check("handshake d1 s", 64'(hs_s1), 64'(exp[W-1:0]));

    // Start held high: one done every NDIG+2 cycles.
    hs_a = $urandom; hs_b = $urandom;
    exp = model(hs_a, hs_b, 1'b0, 1'b1);
    dn = 0;
    @(negedge clk);
    a = hs_a; b = hs_b; ci = 1'b0; sub = 1'b1; start = 1'b1;
    for (int e = 1; e <= 35; e++) begin
      @(posedge clk); #1;
      if (done_v[0]) begin
        d4e.push_back(e);
        check($sformatf("held d4 s #%0d", dn), 64'(s_v[0]), 64'(exp[W-1:0]));
        dn++;
      end
      if (done_v[2]) d32e.push_back(e);
    end
    @(negedge clk); start = 1'b0;
    repeat (45) @(posedge clk);
    while (d4e.size() < 3) d4e.push_back(0);
    while (d32e.size() < 2) d32e.push_back(0);
    check("held d4 first", 64'(d4e[0]), 64'd9);
    check("held d4 period1", 64'(d4e[1] - d4e[0]), 64'd10);
    check("held d4 period2", 64'(d4e[2] - d4e[1]), 64'd10);
    check("held d32 first", 64'(d32e[0]), 64'd2);
    check("held d32 period", 64'(d32e[1] - d32e[0]), 64'd3);

    // Make the previous result nonzero with co=1 so the reset clear is visible.
    run_op("prerst", 32'hF234_5678, 32'hF111_1111, 1'b0, 1'b0, rs, rc, ro);
    @(negedge clk);
    a = 32'h1234_5678; b = 32'h1111_1111; ci = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("midrun d4 busy", 64'(busy_v[0]), 64'd1);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("abort d%0d busy", dig_of(k)), 64'(busy_v[k]), 64'd0);
      check($sformatf("abort d%0d done", dig_of(k)), 64'(done_v[k]), 64'd0);
      check($sformatf("abort d%0d s", dig_of(k)), 64'(s_v[k]), 64'd0);
      check($sformatf("abort d%0d co", dig_of(k)), 64'(co_v[k]), 64'd0);
      check($sformatf("abort d%0d ovf", dig_of(k)), 64'(ovf_v[k]), 64'd0);
    end
    #2 rst_n = 1'b1;
    rs_e = 0;
    for (int e = 0; e < 45; e++) begin
      @(posedge clk); #1;
      if (done_v[0] || done_v[1] || done_v[2]) rs_e++;
    end
    check("post-reset no done", 64'(rs_e), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
